// File: rtl/microwave_input_conditioner_if.sv
// Front-panel bundle: raw contacts into the conditioner, clean pulses and door level out.
interface microwave_input_conditioner_if;
  logic [9:0] raw_keys;
  logic       raw_start;
  logic       raw_clear;
  logic       raw_stop;
  logic       raw_door;
  logic [9:0] keys;
  logic       start;
  logic       clear;
  logic       stop;
  logic       closed_door;
  logic       multi_key;

  modport master (
    output raw_keys, raw_start, raw_clear, raw_stop, raw_door,
    input  keys, start, clear, stop, closed_door, multi_key
  );

  modport slave (
    input  raw_keys, raw_start, raw_clear, raw_stop, raw_door,
    output keys, start, clear, stop, closed_door, multi_key
  );
endinterface

// File: rtl/microwave_input_conditioner.sv
// Synchronizes and debounces keypad/button/door contacts into single-cycle press
// pulses and a stable door level for the microwave top.
module microwave_input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned CNT_W           = 5
) (
  input  logic                           clk,
  input  logic                           rst_n,
  microwave_input_conditioner_if.slave   bus
);

  localparam int unsigned    N_IN     = 14;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Bit map: [9:0] digits, 10 start, 11 clear, 12 stop, 13 door.
  logic [N_IN-1:0]  raw;
  logic [N_IN-1:0]  sync1;
  logic [N_IN-1:0]  sync2;
  logic [N_IN-1:0]  deb;
  logic [N_IN-1:0]  deb_q;
  logic [CNT_W-1:0] cnt [N_IN];

  logic [N_IN-1:0]  rise;
  logic [9:0]       digit_rise;
  logic             single_digit;

  logic [9:0]       keys_q;
  logic             start_q;
  logic             clear_q;
  logic             stop_q;
  logic             multi_q;

  assign raw = {bus.raw_door, bus.raw_stop, bus.raw_clear, bus.raw_start, bus.raw_keys};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb <= '0;
      for (int unsigned i = 0; i < N_IN; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < N_IN; i++) begin
        if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          deb[i] <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign rise       = deb & ~deb_q;
  assign digit_rise = rise[9:0];
  // A digit rise is clean only if it is the sole digit currently held.
  assign single_digit = (deb[9:0] != '0) && ((deb[9:0] & (deb[9:0] - 1'b1)) == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_q   <= '0;
      keys_q  <= '0;
      start_q <= 1'b0;
      clear_q <= 1'b0;
      stop_q  <= 1'b0;
      multi_q <= 1'b0;
    end else begin
      deb_q   <= deb;
      start_q <= rise[10];
      clear_q <= rise[11];
      stop_q  <= rise[12];
      keys_q  <= ((digit_rise != '0) && single_digit) ? digit_rise : '0;
      multi_q <= (digit_rise != '0) && !single_digit;
    end
  end

  assign bus.keys        = keys_q;
  assign bus.start       = start_q;
  assign bus.clear       = clear_q;
  assign bus.stop        = stop_q;
  assign bus.multi_key   = multi_q;
  assign bus.closed_door = deb_q[13];

endmodule

// File: tb/tb_microwave_input_conditioner.sv
// Scoreboard bench: each stable input change queues its expected output event at
// a fixed latency; a per-cycle monitor compares outputs against the queue head.
module tb_microwave_input_conditioner;

  localparam int unsigned LAT = 19;

  typedef struct {
    int unsigned cyc;
    logic [13:0] pulses;
    logic        door_chg;
    logic        door;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  microwave_input_conditioner_if bus ();

  microwave_input_conditioner #(.DEBOUNCE_CYCLES(16), .CNT_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  ev_t         sb[$];
  int unsigned cyc = 0;
  int unsigned n_tests = 0;
  int unsigned n_fail = 0;
  logic        door_exp = 1'b0;
  logic        mon_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [13:0] pulse_vec();
    return {bus.keys, bus.start, bus.clear, bus.stop, bus.multi_key};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    logic [13:0] exp_p;
    ev_t         ev;
    if (mon_en) begin
      exp_p = '0;
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        ev    = sb.pop_front();
        exp_p = ev.pulses;
        if (ev.door_chg) door_exp = ev.door;
      end
      check("pulses", 32'(pulse_vec()), 32'(exp_p));
      check("closed_door", 32'(bus.closed_door), 32'(door_exp));
    end
  end

  task automatic step(input int unsigned n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic expect_ev(input logic [9:0] k, input logic s, input logic c, input logic p,
                           input logic m, input logic dc, input logic d);
    ev_t ev;
    ev.cyc      = cyc + LAT;
    ev.pulses   = {k, s, c, p, m};
    ev.door_chg = dc;
    ev.door     = d;
    sb.push_back(ev);
  endtask

  task automatic check_idle(input string tag);
    check(tag, 32'({pulse_vec(), bus.closed_door}), 32'd0);
  endtask

  initial begin
    bus.raw_keys  = '1;
    bus.raw_start = 1'b1;
    bus.raw_clear = 1'b1;
    bus.raw_stop  = 1'b1;
    bus.raw_door  = 1'b1;
    #2 rst_n = 1'b0;
    #1 check_idle("reset_async");
    step(4);
    check_idle("reset_held");
    bus.raw_keys  = '0;
    bus.raw_start = 1'b0;
    bus.raw_clear = 1'b0;
    bus.raw_stop  = 1'b0;
    bus.raw_door  = 1'b0;
    step(3);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    step(25);

    // Clean digit 3 press, held, then released
    bus.raw_keys = 10'b0000001000;
    expect_ev(10'b0000001000, 0, 0, 0, 0, 0, 0);
    step(40);
    bus.raw_keys = '0;
    step(25);

    // Bouncing start, then held
    bus.raw_start = 1; step(5);
    bus.raw_start = 0; step(4);
    bus.raw_start = 1; step(3);
    bus.raw_start = 0; step(4);
    bus.raw_start = 1; step(10);
    bus.raw_start = 0; step(4);
    bus.raw_start = 1;
    expect_ev('0, 1, 0, 0, 0, 0, 0);
    step(30);
    bus.raw_start = 0; step(25);

    // 15-cycle pulse rejected, 16-cycle pulse accepted
    bus.raw_start = 1; step(15);
    bus.raw_start = 0; step(25);
    bus.raw_start = 1;
    expect_ev('0, 1, 0, 0, 0, 0, 0);
    step(16);
    bus.raw_start = 0; step(25);

    // Simultaneous digits 2 and 7
    bus.raw_keys = 10'b0010000100;
    expect_ev('0, 0, 0, 0, 1, 0, 0);
    step(30);
    bus.raw_keys = '0; step(25);

    // Hold 2, then add 5
    bus.raw_keys = 10'b0000000100;
    expect_ev(10'b0000000100, 0, 0, 0, 0, 0, 0);
    step(25);
    bus.raw_keys = 10'b0000100100;
    expect_ev('0, 0, 0, 0, 1, 0, 0);
    step(25);
    bus.raw_keys = '0; step(25);
    bus.raw_keys = 10'b0000100000;
    expect_ev(10'b0000100000, 0, 0, 0, 0, 0, 0);
    step(25);
    bus.raw_keys = '0; step(25);

    // Door close, short open glitch, sustained open
    bus.raw_door = 1;
    expect_ev('0, 0, 0, 0, 0, 1, 1);
    step(30);
    bus.raw_door = 0; step(8);
    bus.raw_door = 1; step(30);
    bus.raw_door = 0;
    expect_ev('0, 0, 0, 0, 0, 1, 0);
    step(30);

    // Clear and stop together
    bus.raw_clear = 1;
    bus.raw_stop  = 1;
    expect_ev('0, 0, 1, 1, 0, 0, 0);
    step(30);
    bus.raw_clear = 0;
    bus.raw_stop  = 0;
    step(25);

    // Reset while clear/stop still debouncing
    bus.raw_clear = 1;
    bus.raw_stop  = 1;
    expect_ev('0, 0, 1, 1, 0, 0, 0);
    step(12);
    rst_n    = 1'b0;
    mon_en   = 1'b0;
    sb.delete();
    door_exp = 1'b0;
    #1 check_idle("reset_mid");
    step(3);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    expect_ev('0, 0, 1, 1, 0, 0, 0);
    step(30);
    bus.raw_clear = 0;
    bus.raw_stop  = 0;
    step(25);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
